aes_dec_round_seq: RTL and testbench

Iterative AES-128 decryption sequencer. Accepts one 128-bit ciphertext block and drives the shared inverse-round datapath (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns) once per cycle through rounds 10..0. It requests round keys from the external key store by index and returns the plaintext block over a valid/ready handshake. It sits between the RISC-V custom-instruction front end and the inverse-round primitives.

---
 rtl/aes_dec_pkg.sv | 58 +++++
 rtl/aes_inv_round.sv | 33 +++
 rtl/aes_dec_round_seq.sv | 115 +++++++++++
 tb/tb_aes_dec_round_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES-128 decryption path.
// No ports. Provides the sequencer state enum, the word and block types, and
// the byte-level inverse S-box / InvMixColumns functions.
package aes_dec_pkg;
  localparam int NR = 10;

  typedef logic [31:0] word_t;
  typedef word_t block_t [4];

  typedef enum logic [2:0] {IDLE, INIT, ROUND, FINAL, DONE} state_e;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [7:0] gf_inv(logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] res;
    sq  = x;
    res = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      res = gf_mul(res, sq);
    end
    return res;
  endfunction

  // Undo the S-box affine map, then invert in the field. Computed rather
  // than tabulated so there is no 256-entry constant to mistype.
  function automatic logic [7:0] inv_sbox(logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  // One column; byte 0 (bits [7:0]) is row 0.
  function automatic word_t inv_mix_col(word_t a);
    logic [7:0] a0, a1, a2, a3;
    a0 = a[7:0];
    a1 = a[15:8];
    a2 = a[23:16];
    a3 = a[31:24];
    return {gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09)};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> (optional) InvMixColumns.
// Ports:
//   state_i [col][32] : input state, row 0 in bits [7:0] of each column
//   rk_i    [col][32] : round key, same packing
//   mix_en            : 0 bypasses InvMixColumns (last round)
//   state_o [col][32] : round result
module aes_inv_round (
  input  logic [3:0][31:0] state_i,
  input  logic [3:0][31:0] rk_i,
  input  logic             mix_en,
  output logic [3:0][31:0] state_o
);
  import aes_dec_pkg::*;

  logic [3:0][3:0][7:0] sr;   // [col][row]
  logic [3:0][3:0][7:0] sb;
  logic [3:0][31:0]     ark;
  logic [3:0][31:0]     mix;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      // Row r of column c comes from column (c - r) mod 4.
      localparam int SC = (c + 4 - r) % 4;
      assign sr[c][r] = state_i[SC][8*r +: 8];
      assign sb[c][r] = inv_sbox(sr[c][r]);
    end
    assign ark[c] = sb[c] ^ rk_i[c];
    assign mix[c] = inv_mix_col(ark[c]);
  end

  assign state_o = mix_en ? mix : ark;
endmodule

// File: rtl/aes_dec_round_seq.sv
// Iterative AES-128 decryption sequencer. Accepts one ciphertext block,
// walks the shared inverse round through keys 10..0 (one round per cycle),
// then presents the plaintext until the consumer takes it.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   s_valid/s_ready       : ciphertext handshake (ready only in IDLE)
//   s_data0..3            : ciphertext columns, row 0 in bits [7:0]
//   m_valid/m_ready       : plaintext handshake
//   m_data0..3            : plaintext columns
//   rk_idx, rk0..3        : round-key request / zero-latency key store reply
//   busy                  : any state other than IDLE
module aes_dec_round_seq #(
  parameter int NR = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data0,
  input  logic [31:0] s_data1,
  input  logic [31:0] s_data2,
  input  logic [31:0] s_data3,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data0,
  output logic [31:0] m_data1,
  output logic [31:0] m_data2,
  output logic [31:0] m_data3,
  output logic [3:0]  rk_idx,
  input  logic [31:0] rk0,
  input  logic [31:0] rk1,
  input  logic [31:0] rk2,
  input  logic [31:0] rk3,
  output logic        busy
);
  import aes_dec_pkg::*;

  state_e           fsm_q, fsm_d;
  logic [3:0]       rnd_q, rnd_d;
  logic [3:0][31:0] state_q, state_d;
  logic [3:0][31:0] rk;
  logic [3:0][31:0] rnd_out;
  logic             mix_en;

  assign rk     = {rk3, rk2, rk1, rk0};
  assign mix_en = (fsm_q == ROUND);

  aes_inv_round u_round (
    .state_i (state_q),
    .rk_i    (rk),
    .mix_en  (mix_en),
    .state_o (rnd_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    unique case (fsm_q)
      IDLE: if (s_valid) begin
        state_d = {s_data3, s_data2, s_data1, s_data0};
        fsm_d   = INIT;
      end
      INIT: begin
        state_d = state_q ^ rk;
        rnd_d   = 4'(NR - 1);
        fsm_d   = ROUND;
      end
      ROUND: begin
        state_d = rnd_out;
        if (rnd_q == 4'd1) fsm_d = FINAL;
        else               rnd_d = rnd_q - 4'd1;
      end
      FINAL: begin
        state_d = rnd_out;
        fsm_d   = DONE;
      end
      DONE: if (m_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rnd_q   <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
    end
  end

  // Outputs depend on registered state only.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    rk_idx  = 4'd0;
    unique case (fsm_q)
      IDLE:    begin s_ready = 1'b1; busy = 1'b0; end
      INIT:    rk_idx = 4'(NR);
      ROUND:   rk_idx = rnd_q;
      FINAL:   rk_idx = 4'd0;
      DONE:    m_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  assign m_data0 = state_q[0];
  assign m_data1 = state_q[1];
  assign m_data2 = state_q[2];
  assign m_data3 = state_q[3];
endmodule

// File: tb/tb_aes_dec_round_seq.sv
// Bench for aes_dec_round_seq: FIPS-197 C.1 vector, rk_idx probe,
// backpressure, input-while-busy, mid-operation reset, back-to-back blocks
// and random key/ciphertext blocks against a byte-array AES model.
module tb_aes_dec_round_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0, s_ready;
  logic [31:0] s_data0 = '0, s_data1 = '0, s_data2 = '0, s_data3 = '0;
  logic        m_valid, m_ready = 1'b1;
  logic [31:0] m_data0, m_data1, m_data2, m_data3;
  logic [3:0]  rk_idx;
  logic [31:0] rk0, rk1, rk2, rk3;
  logic        busy;

  logic [7:0]  sbox [256];
  logic [7:0]  isbox[256];
  logic [31:0] rkw  [44];

  int errs = 0;
  int checks = 0;

  localparam logic [127:0] C1_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] C1_CT  = 128'h5ac5b470_80b7cdd8_30047b6a_d8e0c469;
  localparam logic [127:0] C1_PT  = 128'hffeeddcc_bbaa9988_77665544_33221100;

  always #5 clk = ~clk;

  aes_dec_round_seq #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_data0(s_data0), .s_data1(s_data1), .s_data2(s_data2), .s_data3(s_data3),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_data0(m_data0), .m_data1(m_data1), .m_data2(m_data2), .m_data3(m_data3),
    .rk_idx(rk_idx), .rk0(rk0), .rk1(rk1), .rk2(rk2), .rk3(rk3),
    .busy(busy)
  );

  // Zero-latency key store.
  assign rk0 = (rk_idx <= 4'd10) ? rkw[int'(rk_idx) * 4 + 0] : '0;
  assign rk1 = (rk_idx <= 4'd10) ? rkw[int'(rk_idx) * 4 + 1] : '0;
  assign rk2 = (rk_idx <= 4'd10) ? rkw[int'(rk_idx) * 4 + 2] : '0;
  assign rk3 = (rk_idx <= 4'd10) ? rkw[int'(rk_idx) * 4 + 3] : '0;

  wire [127:0] m_blk = {m_data3, m_data2, m_data1, m_data0};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Carry-less product, then polynomial long division by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (32'h11b << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic key_exp(input logic [127:0] key);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) rkw[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = rkw[i-1];
      if (i % 4 == 0) begin
        t = {t[7:0], t[31:8]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {24'h0, rc};
        rc = gmul(rc, 8'h02);
      end
      rkw[i] = rkw[i-4] ^ t;
    end
  endtask

  function automatic logic [127:0] model_dec(input logic [127:0] ct);
    logic [7:0]   st [4][4];   // [row][col]
    logic [7:0]   tmp[4][4];
    logic [127:0] pt;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        st[r][c] = ct[32*c + 8*r +: 8] ^ rkw[40 + c][8*r +: 8];
    for (int rd = 9; rd >= 0; rd--) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          tmp[r][c] = isbox[st[r][(c - r + 4) % 4]] ^ rkw[4*rd + c][8*r +: 8];
      for (int c = 0; c < 4; c++) begin
        if (rd > 0) begin
          st[0][c] = gmul(tmp[0][c], 14) ^ gmul(tmp[1][c], 11) ^ gmul(tmp[2][c], 13) ^ gmul(tmp[3][c], 9);
          st[1][c] = gmul(tmp[0][c], 9)  ^ gmul(tmp[1][c], 14) ^ gmul(tmp[2][c], 11) ^ gmul(tmp[3][c], 13);
          st[2][c] = gmul(tmp[0][c], 13) ^ gmul(tmp[1][c], 9)  ^ gmul(tmp[2][c], 14) ^ gmul(tmp[3][c], 11);
          st[3][c] = gmul(tmp[0][c], 11) ^ gmul(tmp[1][c], 13) ^ gmul(tmp[2][c], 9)  ^ gmul(tmp[3][c], 14);
        end else begin
          for (int r = 0; r < 4; r++) st[r][c] = tmp[r][c];
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pt[32*c + 8*r +: 8] = st[r][c];
    return pt;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_s(input logic [127:0] d);
    {s_data3, s_data2, s_data1, s_data0} = d;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ":s_ready"}, s_ready, 1);
    chk({tag, ":m_valid"}, m_valid, 0);
    chk({tag, ":busy"},    busy,    0);
    chk({tag, ":rk_idx"},  rk_idx,  0);
    chk({tag, ":m_data"},  m_blk,   0);
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_block(input string tag, input logic [127:0] ct, input logic [127:0] exp,
                           input int hold, input bit inject);
    int cyc;
    logic [127:0] held;
    chk({tag, ":idle_rdy"}, s_ready, 1);
    chk({tag, ":idle_rk"},  rk_idx,  0);
    s_valid = 1'b1;
    drive_s(ct);
    m_ready = (hold == 0);
    @(negedge clk);
    s_valid = 1'b0;
    drive_s({$urandom, $urandom, $urandom, $urandom});
    cyc = 1;
    while (cyc < 40 && !m_valid) begin
      chk($sformatf("%s:rk_c%0d", tag, cyc), rk_idx, (cyc <= 11) ? 11 - cyc : 0);
      if (inject && cyc == 4) begin
        chk({tag, ":busy_rdy"}, s_ready, 0);
        s_valid = 1'b1;
        drive_s({$urandom, $urandom, $urandom, $urandom});
      end
      if (inject && cyc == 5) s_valid = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk({tag, ":latency"}, cyc, 12);
    chk({tag, ":data"},    m_blk, exp);
    chk({tag, ":done_rk"}, rk_idx, 0);
    held = m_blk;
    for (int h = 0; h < hold; h++) begin
      chk($sformatf("%s:bp_hold%0d", tag, h), m_blk, held);
      chk($sformatf("%s:bp_rdy%0d", tag, h), s_ready, 0);
      chk($sformatf("%s:bp_vld%0d", tag, h), m_valid, 1);
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    chk({tag, ":ret_rdy"}, s_ready, 1);
    chk({tag, ":ret_vld"}, m_valid, 0);
  endtask

  initial begin
    logic [127:0] ct_b, key;
    int first, second, acc2;
    bit drop;

    build_sbox();
    key_exp(C1_KEY);

    #12;
    chk_reset_outs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outs("post_rel");

    // Known-answer vector with 5 cycles of backpressure.
    run_block("c1", C1_CT, C1_PT, 5, 1'b0);

    // Second block offered during ROUND must be ignored.
    run_block("busy", C1_CT, C1_PT, 0, 1'b1);

    // Mid-operation reset at cycle 6.
    s_valid = 1'b1;
    drive_s(C1_CT);
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 1; c < 6; c++) @(negedge clk);
    chk("mid:busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outs("mid");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid:vld%0d", c), m_valid, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_block("post_rst", C1_CT, C1_PT, 0, 1'b0);

    // Back-to-back with s_valid held and m_ready tied high.
    ct_b = {$urandom, $urandom, $urandom, $urandom};
    first = 0; second = 0; acc2 = 0; drop = 1'b0;
    m_ready = 1'b1;
    s_valid = 1'b1;
    drive_s(C1_CT);
    @(negedge clk);
    drive_s(ct_b);
    for (int cyc = 1; cyc < 40; cyc++) begin
      if (drop) s_valid = 1'b0;
      if (m_valid && first == 0) begin
        first = cyc;
        chk("b2b:data_a", m_blk, C1_PT);
      end else if (m_valid && second == 0 && acc2 != 0) begin
        second = cyc;
        chk("b2b:data_b", m_blk, model_dec(ct_b));
      end
      if (s_ready && s_valid && acc2 == 0) begin
        acc2 = cyc;
        drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b:first_vld", first, 12);
    chk("b2b:accept2", acc2, 13);
    chk("b2b:second_vld", second, 25);

    // Random keys and blocks.
    for (int n = 0; n < 6; n++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      key_exp(key);
      ct_b = {$urandom, $urandom, $urandom, $urandom};
      run_block($sformatf("rnd%0d", n), ct_b, model_dec(ct_b),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
